tri_pwm_multichannel: RTL and testbench

//  Parametrised multi-channel successor of the single-channel falling-edge / triangular-duty / compare PWM path.

---
 rtl/tri_pwm_pkg.sv | 14 +
 rtl/tri_pwm_multichannel_tri_step_channel.sv | 55 +++++
 rtl/tri_pwm_multichannel.sv | 102 ++++++++++
 tb/tb_tri_pwm_multichannel.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pwm_pkg.sv
// Shared constants and helpers for the multi-channel triangle-duty PWM block.
package tri_pwm_pkg;

  localparam logic MODE_SAW    = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int max_val(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/tri_pwm_multichannel_tri_step_channel.sv
// One channel: falling-edge detect driving a saturating up/down triangle duty value.
module tri_step_channel
  import tri_pwm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] tri_val
);

  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(max_val(WIDTH));
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  logic           prev_in;
  logic           dir;
  logic           fall;
  logic [WIDTH:0] sum_ext;

  assign fall    = prev_in & ~in;
  // One extra bit so the saturation test cannot be fooled by wrap-around.
  assign sum_ext = {1'b0, tri_val} + STEP_EXT;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_in <= 1'b0;
      tri_val <= '0;
      dir     <= DIR_UP;
    end else begin
      prev_in <= in;
      if (fall) begin
        if (dir == DIR_UP) begin
          if (sum_ext >= MAX_EXT) begin
            tri_val <= MAX_W;
            dir     <= DIR_DOWN;
          end else begin
            tri_val <= sum_ext[WIDTH-1:0];
          end
        end else begin
          if ({1'b0, tri_val} <= STEP_EXT) begin
            tri_val <= '0;
            dir     <= DIR_UP;
          end else begin
            tri_val <= tri_val - STEP_W;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tri_pwm_multichannel.sv
// Multi-channel PWM: shared sawtooth/centre-aligned carrier, per-channel triangle
// duty steppers, duty double-buffered and committed at carrier period boundaries.
module tri_pwm_multichannel
  import tri_pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*WIDTH-1:0] duty,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0]          carrier;
  logic                      carrier_dir;
  logic                      mode_q;
  logic                      boundary;
  logic [WIDTH-1:0]          tri_vals [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] active;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tri_step_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_step (
      .clk     (clk),
      .rst     (rst),
      .in      (in[i]),
      .tri_val (tri_vals[i])
    );
  end

  // Boundary is the enabled cycle whose successor carrier value is 0.
  always_comb begin
    boundary = 1'b0;
    if (en) begin
      if (mode_q == MODE_SAW) begin
        boundary = (carrier == MAX_W);
      end else begin
        boundary = (carrier == ONE_W) && (carrier_dir == DIR_DOWN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carrier     <= '0;
      carrier_dir <= DIR_UP;
      mode_q      <= MODE_SAW;
    end else if (en) begin
      if (boundary) begin
        carrier     <= '0;
        carrier_dir <= DIR_UP;
        mode_q      <= mode;
      end else if (mode_q == MODE_SAW) begin
        carrier <= carrier + ONE_W;
      end else if (carrier_dir == DIR_UP) begin
        if (carrier == MAX_W) begin
          carrier     <= MAX_W - ONE_W;
          carrier_dir <= DIR_DOWN;
        end else begin
          carrier <= carrier + ONE_W;
        end
      end else begin
        carrier <= carrier - ONE_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else if (boundary) begin
      for (int i = 0; i < CHANNELS; i++) begin
        active[i*WIDTH +: WIDTH] <= tri_vals[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= en & (active[i*WIDTH +: WIDTH] > carrier);
      end
    end
  end

  assign duty         = active;
  assign period_start = en & (carrier == '0);

endmodule

// File: tb/tb_tri_pwm_multichannel.sv
// Directed bench: table of edge bursts with committed-duty expectations, plus
// hand sequences for carrier modes, boundary-cycle edges, enable freeze and reset.
module tb_tri_pwm_multichannel;

  localparam int W  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            mode;
  logic [CH-1:0]   in_a;
  logic [0:0]      in_b;
  logic [CH-1:0]   pwm_a;
  logic [CH*W-1:0] duty_a;
  logic            ps_a;
  logic [0:0]      pwm_b;
  logic [W-1:0]    duty_b;
  logic            ps_b;

  int checks = 0;
  int errors = 0;
  int cnt [CH];

  typedef struct {
    bit          on_b;
    logic [3:0]  mask;
    int          reps;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [11];

  tri_pwm_multichannel #(.WIDTH(W), .CHANNELS(CH), .STEP(1)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .in           (in_a),
    .pwm_out      (pwm_a),
    .duty         (duty_a),
    .period_start (ps_a)
  );

  tri_pwm_multichannel #(.WIDTH(W), .CHANNELS(1), .STEP(100)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .in           (in_b),
    .pwm_out      (pwm_b),
    .duty         (duty_b),
    .period_start (ps_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] ma, input logic mb);
    in_a = in_a & ~ma;
    in_b = in_b & ~mb;
    @(negedge clk);
    in_a = in_a | ma;
    in_b = in_b | mb;
    @(negedge clk);
  endtask

  // Leaves us at the first negedge of a fresh period started after the call.
  task automatic waitBoundary();
    int n;
    n = 0;
    while (ps_a === 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    while (ps_a !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1100) begin
      checks++;
      errors++;
      $display("[TB] FAIL boundary_timeout actual=%0d expected<1100", n);
    end
  endtask

  task automatic countPeriod(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) cnt[c] += int'(pwm_a[c]);
    end
  endtask

  task automatic clearCounts();
    for (int c = 0; c < CH; c++) cnt[c] = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    repeat (v.reps) pulse(v.on_b ? 4'b0000 : v.mask, v.on_b ? v.mask[0] : 1'b0);
    waitBoundary();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    in_a = '1;
    in_b = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    rst  = 1'b1;

    vecs[0]  = '{1'b0, 4'b0001, 3, 32'h00000003, "ch0_three_falls"};
    vecs[1]  = '{1'b1, 4'b0001, 1, 32'h00000064, "step100_e1"};
    vecs[2]  = '{1'b1, 4'b0001, 1, 32'h000000C8, "step100_e2"};
    vecs[3]  = '{1'b1, 4'b0001, 1, 32'h000000FF, "step100_sat_max"};
    vecs[4]  = '{1'b1, 4'b0001, 1, 32'h0000009B, "step100_down1"};
    vecs[5]  = '{1'b1, 4'b0001, 1, 32'h00000037, "step100_down2"};
    vecs[6]  = '{1'b1, 4'b0001, 1, 32'h00000000, "step100_sat_zero"};
    vecs[7]  = '{1'b1, 4'b0001, 1, 32'h00000064, "step100_up_again"};
    vecs[8]  = '{1'b0, 4'b0110, 5, 32'h00050503, "ch12_five_falls"};
    vecs[9]  = '{1'b0, 4'b1010, 2, 32'h02050703, "ch13_two_falls"};
    vecs[10] = '{1'b0, 4'b1000, 8, 32'h0A050703, "ch3_to_ten"};

    waitCycles(2);
    checkOutput("reset_pwm", 32'(pwm_a), 32'h0);
    checkOutput("reset_duty", duty_a, 32'h0);
    checkOutput("reset_duty_b", 32'(duty_b), 32'h0);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("idle_period_start_en0", 32'(ps_a), 32'h0);
    en = 1'b1;
    #1;
    checkOutput("first_en_period_start", 32'(ps_a), 32'h1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].on_b) checkOutput(vecs[i].name, 32'(duty_b), vecs[i].exp);
      else              checkOutput(vecs[i].name, duty_a, vecs[i].exp);
    end

    clearCounts();
    countPeriod(256);
    checkOutput("saw_high_ch0", cnt[0], 3);
    checkOutput("saw_high_ch1", cnt[1], 7);
    checkOutput("saw_high_ch2", cnt[2], 5);
    checkOutput("saw_high_ch3", cnt[3], 10);
    checkOutput("saw_period_256", 32'(ps_a), 32'h1);

    // Fall landing exactly on the boundary edge commits one period late.
    waitCycles(255);
    in_a[0] = 1'b0;
    @(negedge clk);
    in_a[0] = 1'b1;
    checkOutput("bnd_fall_at_start", 32'(ps_a), 32'h1);
    checkOutput("bnd_fall_duty_old", 32'(duty_a[7:0]), 32'd3);
    waitBoundary();
    checkOutput("bnd_fall_duty_new", 32'(duty_a[7:0]), 32'd4);

    // Mode change mid-period must wait for the sawtooth wrap.
    waitCycles(50);
    mode = 1'b1;
    n = 0;
    while (ps_a !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mode_switch_delay", n, 206);
    clearCounts();
    countPeriod(256);
    checkOutput("centre_no_wrap_256", 32'(ps_a), 32'h0);
    countPeriod(254);
    checkOutput("centre_period_510", 32'(ps_a), 32'h1);
    checkOutput("centre_high_ch0", cnt[0], 7);
    checkOutput("centre_high_ch1", cnt[1], 13);
    checkOutput("centre_high_ch2", cnt[2], 9);
    checkOutput("centre_high_ch3", cnt[3], 19);

    mode = 1'b0;
    waitBoundary();

    // Enable freeze: outputs drop at once, carrier resumes where it stopped.
    waitCycles(3);
    checkOutput("pre_freeze_pwm", 32'(pwm_a), 32'hF);
    en = 1'b0;
    @(negedge clk);
    checkOutput("freeze_pwm_low", 32'(pwm_a), 32'h0);
    waitCycles(5);
    checkOutput("freeze_pwm_hold", 32'(pwm_a), 32'h0);
    en = 1'b1;
    waitCycles(34);
    en = 1'b0;
    @(negedge clk);
    checkOutput("freeze37_pwm", 32'(pwm_a), 32'h0);
    checkOutput("freeze37_ps", 32'(ps_a), 32'h0);
    waitCycles(10);
    en = 1'b1;
    waitCycles(218);
    checkOutput("resume_carrier_255", 32'(ps_a), 32'h0);
    waitCycles(1);
    checkOutput("resume_carrier_wrap", 32'(ps_a), 32'h1);

    // Reset in the middle of a period.
    waitCycles(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_duty", duty_a, 32'h0);
    checkOutput("midrst_duty_b", 32'(duty_b), 32'h0);
    checkOutput("midrst_pwm", 32'(pwm_a), 32'h0);
    checkOutput("midrst_carrier0", 32'(ps_a), 32'h1);
    waitCycles(255);
    checkOutput("midrst_saw_255", 32'(ps_a), 32'h0);
    waitCycles(1);
    checkOutput("midrst_saw_wrap", 32'(ps_a), 32'h1);
    checkOutput("midrst_no_edge", duty_a, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
